instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Program-memory end of the sequencer/instruction interface: takes the 8-bit `InstrAddr` produced by the sequencer FSM and fetches the 16-bit instruction word from a loadable program store.
- Decodes the fetched word into datapath control fields.
- Holds the registered condition-flag register whose bit 0 the sequencer samples for its branch decisions.
- Sits between the sequencer, the ALU/register-file datapath and the program-load port.

Parameters:
- DEPTH, 32: program words; valid addresses 0..DEPTH-1.
- IW, 16: instruction width.
- AW, 8: width of `InstrAddr`.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `InstrAddr`  in  AW  fetch address from sequencer
- `load_en`  in  1  program-load strobe; one word written per cycle
- `load_addr`  in  5  program write address
- `load_data`  in  IW  program write data
- `alu_flags_in`  in  4  raw ALU flags {N,C,V,Z} for the instruction currently decoded
- `Instr`  out  IW  registered fetched word
- `instr_valid`  out  1  `Instr`/decode fields are meaningful this cycle
- `opcode`  out  4  `Instr[15:12]`
- `rd`  out  3  `Instr[11:9]`
- `ra`  out  3  `Instr[8:6]`
- `rb_imm`  out  6  `Instr[5:0]`
- `reg_we`  out  1  register-file write enable
- `flag_we`  out  1  current instruction updates flags
- `illegal`  out  1  one-cycle pulse: opcode 8..15 fetched
- `ALUFlags`  out  4  registered flags {N,C,V,Z}; bit 0 = Z, fed back to the sequencer

Behaviour:
- Reset (`reset`=0, asynchronous): FSM to RUN.
  - Outputs go to zero: `Instr`, all fields, `instr_valid`, `reg_we`, `flag_we`, `illegal`, `ALUFlags`.
  - Program memory is not reset; contents are undefined until loaded.
- FSM states: RUN, LOAD, FLUSH.
  - RUN -> LOAD when `load_en`=1.
  - LOAD stays while `load_en`=1.
  - LOAD -> FLUSH when `load_en`=0.
  - FLUSH -> RUN unconditionally after one cycle.
- LOAD state:
  - `mem[load_addr]` <= `load_data` on each edge with `load_en`=1.
  - `load_addr` >= DEPTH is ignored (no write).
  - `instr_valid`, `reg_we`, `flag_we` and `illegal` are forced to 0; `ALUFlags` holds.
- FLUSH state: same output gating as LOAD.
  - Performs one fetch from the current `InstrAddr` so the first RUN cycle sees freshly loaded data.
- Fetch (RUN and FLUSH):
  - `Instr` <= `mem[InstrAddr]` at each rising edge: 1-cycle latency from `InstrAddr` to `Instr`.
  - `InstrAddr` >= DEPTH fetches 16'h0000 (NOP).
- `instr_valid`: 1 in every RUN cycle after the first RUN edge.
- Decode (combinational from registered `Instr`, gated by `instr_valid`):
  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 CMP, 6 MOVI, 7 HALT.
  - `reg_we` = 1 for opcodes 1..4 and 6.
  - `flag_we` = 1 for opcodes 1..5.
  - Opcodes 8..15: `reg_we`=`flag_we`=0; `illegal`=1 for that one valid cycle.
  - HALT: no writes.
- Flag register: `ALUFlags` <= `alu_flags_in` at an edge where `flag_we`=1; otherwise it holds.
  - Sequencer sees the updated Z one cycle after the flag-setting instruction is decoded.
- Simultaneous events:
  - `load_en` rising in the same cycle as a flag-setting decode: the flag update is suppressed, because decoding is gated from the LOAD transition edge onward.
  - Same-address load and fetch in LOAD: the fetch result is discarded.
- Reset mid-LOAD: the write in progress is abandoned. Words written before reset are retained.
- Wrap-around: none. Address is used as-is; out-of-range addresses yield NOP.

Test Plan:
- Reset: assert `reset`=0 mid-run with `ALUFlags`=4'b0001 -> all outputs 0 immediately; after release, first valid `Instr` appears one edge later.
- Load/fetch: load `mem[0]`=16'h1A85, `mem[1]`=16'h5000, then `InstrAddr`=0 -> `Instr`=16'h1A85 one cycle later, `opcode`=1, `rd`=5, `ra`=2, `rb_imm`=5, `reg_we`=1, `flag_we`=1.
- Flag path: CMP (16'h5000) with `alu_flags_in`=4'b0001 -> `ALUFlags`=4'b0001 after the edge. A following MOVI (16'h6203) with `alu_flags_in`=4'b1000 -> `ALUFlags` stays 4'b0001.
- Load gating: raise `load_en` while an ADD is decoded -> `instr_valid`=0 from the next cycle. `ALUFlags` unchanged through LOAD and FLUSH; RUN resumes exactly two cycles after `load_en` falls.
- Illegal/out-of-range: word 16'hF000 -> `illegal` pulses 1 cycle, no `reg_we`/`flag_we`. `InstrAddr`=8'd40 -> `Instr`=16'h0000.
- Boundary: `load_addr`=31 writes; `InstrAddr`=31 held for 5 cycles -> identical `Instr` every cycle. A HALT word at 31 produces no writes.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Program store, fetch register, instruction decode and condition-flag
// register sitting between the sequencer, the datapath and the load port.
module instr_fetch_decode #(
    parameter int DEPTH = 32,
    parameter int IW    = 16,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] InstrAddr,
    input  logic          load_en,
    input  logic [4:0]    load_addr,
    input  logic [IW-1:0] load_data,
    input  logic [3:0]    alu_flags_in,
    output logic [IW-1:0] Instr,
    output logic          instr_valid,
    output logic [3:0]    opcode,
    output logic [2:0]    rd,
    output logic [2:0]    ra,
    output logic [5:0]    rb_imm,
    output logic          reg_we,
    output logic          flag_we,
    output logic          illegal,
    output logic [3:0]    ALUFlags
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        FLUSH
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic [3:0]    r_flags;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [IW-1:0] w_fetch;
    logic          w_reg_we;
    logic          w_flag_we;
    logic          w_illegal;

    assign w_wr_ok = int'(load_addr) < DEPTH;
    assign w_rd_ok = int'(InstrAddr) < DEPTH;
    assign w_fetch = w_rd_ok ? r_mem[InstrAddr[MAW-1:0]] : '0;

    // Store is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && load_en && w_wr_ok) begin
            r_mem[load_addr[MAW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_flags <= '0;
        end else begin
            // Decode is gated from the edge that enters LOAD onward.
            if (w_flag_we && !load_en) begin
                r_flags <= alu_flags_in;
            end
            unique case (r_state)
                RUN: begin
                    r_instr <= w_fetch;
                    r_valid <= !load_en;
                    if (load_en) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_valid <= 1'b0;
                    if (!load_en) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_instr <= w_fetch;
                    r_valid <= 1'b1;
                    r_state <= RUN;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_reg_we  = 1'b0;
        w_flag_we = 1'b0;
        w_illegal = 1'b0;
        if (r_valid) begin
            case (r_instr[15:12]) inside
                [4'd1:4'd4]: begin
                    w_reg_we  = 1'b1;
                    w_flag_we = 1'b1;
                end
                4'd5:         w_flag_we = 1'b1;
                4'd6:         w_reg_we  = 1'b1;
                [4'd8:4'd15]: w_illegal = 1'b1;
                default: begin
                    w_reg_we  = 1'b0;
                    w_flag_we = 1'b0;
                end
            endcase
        end
    end

    assign Instr       = r_instr;
    assign instr_valid = r_valid;
    assign opcode      = r_instr[15:12];
    assign rd          = r_instr[11:9];
    assign ra          = r_instr[8:6];
    assign rb_imm      = r_instr[5:0];
    assign reg_we      = w_reg_we;
    assign flag_we     = w_flag_we;
    assign illegal     = w_illegal;
    assign ALUFlags    = r_flags;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: decode table, hand-written load/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  InstrAddr = 8'd40;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [3:0]  alu_flags_in = '0;
    logic [15:0] Instr;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [5:0]  rb_imm;
    logic        reg_we;
    logic        flag_we;
    logic        illegal;
    logic [3:0]  ALUFlags;

    instr_fetch_decode dut (
        .clk(clk), .reset(reset), .InstrAddr(InstrAddr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .alu_flags_in(alu_flags_in), .Instr(Instr),
        .instr_valid(instr_valid), .opcode(opcode), .rd(rd), .ra(ra),
        .rb_imm(rb_imm), .reg_we(reg_we), .flag_we(flag_we),
        .illegal(illegal), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: word store plus what the outputs should show.
    logic [15:0] m_mem [32];
    logic [15:0] m_instr;
    logic        m_valid;
    logic [3:0]  m_flags;
    logic        m_prev_le;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  alu;
        logic        rwe;
        logic        fwe;
        logic        ill;
        logic [3:0]  flags;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic m_rwe(logic [15:0] w, logic v);
        return v && (w[15:12] inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6});
    endfunction

    function automatic logic m_fwe(logic [15:0] w, logic v);
        return v && (w[15:12] >= 4'd1) && (w[15:12] <= 4'd5);
    endfunction

    function automatic logic m_ill(logic [15:0] w, logic v);
        return v && (w[15:12] >= 4'd8);
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic m_step();
        if (!reset) begin
            m_instr   = '0;
            m_valid   = 1'b0;
            m_flags   = '0;
            m_prev_le = 1'b0;
        end else begin
            if (m_fwe(m_instr, m_valid) && !load_en) m_flags = alu_flags_in;
            if (!m_prev_le) begin
                m_instr = (InstrAddr < 8'd32) ? m_mem[InstrAddr[4:0]] : 16'h0;
            end
            m_valid = !load_en && !m_prev_le;
            if (load_en) m_mem[load_addr] = load_data;
            m_prev_le = load_en;
        end
    endtask

    task automatic check_all();
        chk("instr", Instr, m_instr);
        chk("valid", 16'(instr_valid), 16'(m_valid));
        chk("opcode", 16'(opcode), 16'(m_instr[15:12]));
        chk("rd", 16'(rd), 16'(m_instr[11:9]));
        chk("ra", 16'(ra), 16'(m_instr[8:6]));
        chk("rb_imm", 16'(rb_imm), 16'(m_instr[5:0]));
        chk("reg_we", 16'(reg_we), 16'(m_rwe(m_instr, m_valid)));
        chk("flag_we", 16'(flag_we), 16'(m_fwe(m_instr, m_valid)));
        chk("illegal", 16'(illegal), 16'(m_ill(m_instr, m_valid)));
        chk("flags", 16'(ALUFlags), 16'(m_flags));
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] w;
        int burst;
        int cool;

        tbl[0] = '{16'h1A85, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[1] = '{16'h5000, 4'h4, 1'b0, 1'b1, 1'b0, 4'h4};
        tbl[2] = '{16'h6203, 4'h1, 1'b1, 1'b0, 1'b0, 4'h1};
        tbl[3] = '{16'h0000, 4'h8, 1'b0, 1'b0, 1'b0, 4'h1};
        tbl[4] = '{16'h2E3F, 4'hF, 1'b1, 1'b1, 1'b0, 4'h1};
        tbl[5] = '{16'h3111, 4'h6, 1'b1, 1'b1, 1'b0, 4'h6};
        tbl[6] = '{16'h4FFF, 4'h9, 1'b1, 1'b1, 1'b0, 4'h9};
        tbl[7] = '{16'h7000, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC};
        tbl[8] = '{16'hF000, 4'h5, 1'b0, 1'b0, 1'b1, 4'hC};
        tbl[9] = '{16'h8ABC, 4'hA, 1'b0, 1'b0, 1'b1, 4'hC};

        m_step();
        #1;
        check_all();
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            load_en   = 1'b1;
            load_addr = 5'(i);
            load_data = tbl[i].word;
            tick();
        end
        load_en = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 10; i++) begin
            InstrAddr    = 8'(i);
            alu_flags_in = tbl[i].alu;
            tick();
            w = tbl[i].word;
            chk("tbl_instr", Instr, w);
            chk("tbl_opcode", 16'(opcode), 16'(w[15:12]));
            chk("tbl_rd", 16'(rd), 16'(w[11:9]));
            chk("tbl_ra", 16'(ra), 16'(w[8:6]));
            chk("tbl_rb", 16'(rb_imm), 16'(w[5:0]));
            chk("tbl_reg_we", 16'(reg_we), 16'(tbl[i].rwe));
            chk("tbl_flag_we", 16'(flag_we), 16'(tbl[i].fwe));
            chk("tbl_illegal", 16'(illegal), 16'(tbl[i].ill));
            chk("tbl_flags", 16'(ALUFlags), 16'(tbl[i].flags));
        end

        InstrAddr = 8'd1;
        alu_flags_in = 4'h0;
        tick();
        InstrAddr = 8'd3;
        alu_flags_in = 4'b0001;
        tick();
        chk("cmp_flags", 16'(ALUFlags), 16'h0001);
        alu_flags_in = 4'h0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        m_step();
        check_all();
        chk("rst_instr", Instr, 16'h0);
        chk("rst_flags", 16'(ALUFlags), 16'h0);
        tick();
        reset = 1'b1;
        InstrAddr = 8'd0;
        chk("rel_valid0", 16'(instr_valid), 16'h0);
        tick();
        chk("rel_valid1", 16'(instr_valid), 16'h1);
        chk("rel_instr", Instr, 16'h1A85);

        load_en = 1'b1;
        load_addr = 5'd31;
        load_data = 16'h7000;
        alu_flags_in = 4'hF;
        tick();
        chk("ld_valid", 16'(instr_valid), 16'h0);
        chk("ld_flags", 16'(ALUFlags), 16'h0);
        load_en = 1'b0;
        InstrAddr = 8'd31;
        tick();
        chk("flush_valid", 16'(instr_valid), 16'h0);
        tick();
        chk("resume_valid", 16'(instr_valid), 16'h1);
        chk("resume_instr", Instr, 16'h7000);
        chk("resume_flags", 16'(ALUFlags), 16'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold31_instr", Instr, 16'h7000);
            chk("halt_reg_we", 16'(reg_we), 16'h0);
            chk("halt_flag_we", 16'(flag_we), 16'h0);
        end
        InstrAddr = 8'd40;
        tick();
        chk("oor_instr", Instr, 16'h0000);
        InstrAddr = 8'd8;
        tick();
        chk("ill_pulse", 16'(illegal), 16'h1);
        InstrAddr = 8'd3;
        tick();
        chk("ill_clear", 16'(illegal), 16'h0);

        InstrAddr = 8'd40;
        for (int i = 0; i < 32; i++) begin
            load_en   = 1'b1;
            load_addr = 5'(i);
            load_data = 16'($urandom);
            tick();
        end
        load_en = 1'b0;
        tick();
        tick();
        burst = 0;
        cool = 0;
        for (int n = 0; n < 400; n++) begin
            if (burst > 0) begin
                load_en = 1'b1;
                burst--;
                if (burst == 0) cool = 2;
            end else if (cool > 0) begin
                load_en = 1'b0;
                cool--;
            end else if ($urandom_range(0, 9) == 0) begin
                load_en = 1'b1;
                burst = $urandom_range(0, 3);
                if (burst == 0) cool = 2;
            end else begin
                load_en = 1'b0;
            end
            InstrAddr    = 8'($urandom_range(0, 40));
            load_addr    = 5'($urandom_range(0, 31));
            load_data    = 16'($urandom);
            alu_flags_in = 4'($urandom);
            tick();
        end

        load_en = 1'b0;
        tick();
        tick();
        load_en = 1'b1;
        load_addr = 5'd20;
        load_data = 16'hBEEF;
        tick();
        load_addr = 5'd22;
        load_data = 16'hDEAD;
        #2;
        reset = 1'b0;
        #1;
        m_step();
        check_all();
        tick();
        load_en = 1'b0;
        reset = 1'b1;
        InstrAddr = 8'd40;
        tick();
        InstrAddr = 8'd20;
        tick();
        chk("kept_word", Instr, 16'hBEEF);
        InstrAddr = 8'd22;
        tick();
        chk("dropped_write", Instr, m_mem[22]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
